// File: rtl/ifetch_responder.sv
// Fetch-side instruction memory: returns {pc, inst, err} in request order LATENCY cycles after accept.
// Credits (occ) cap outstanding requests at DEPTH so the response FIFO cannot overflow; flush drops all in-flight work.
module ifetch_responder #(
  parameter int          LATENCY  = 2,
  parameter int          DEPTH    = 4,
  parameter int          MEM_AW   = 10,
  parameter logic [63:0] MEM_BASE = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [63:0]       req_addr_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [63:0]       resp_pc_o,
  output logic [31:0]       resp_inst_o,
  output logic              resp_err_o,
  input  logic              flush_i,
  input  logic              init_wr_en_i,
  input  logic [MEM_AW-1:0] init_wr_addr_i,
  input  logic [31:0]       init_wr_data_i
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] OCC_MAX  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [63:0]   MEM_SPAN = 64'(4) << MEM_AW;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } resp_t;

  logic [31:0]   mem_q [2**MEM_AW];
  resp_t         fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [63:0]   offset;
  logic          accept, pop, push_vld;
  resp_t         acc_ent, push_ent, head;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign req_ready_o  = (occ_q < OCC_MAX) && !flush_i && rst;
  assign accept       = req_valid_i && req_ready_o;
  assign resp_valid_o = (fcnt_q != '0);
  assign pop          = resp_valid_o && resp_ready_i && !flush_i;
  assign offset       = req_addr_i - MEM_BASE;

  // Combinational read sees pre-edge contents, so a same-edge init write returns old data.
  always_comb begin
    acc_ent.pc   = req_addr_i;
    acc_ent.err  = (req_addr_i[1:0] != 2'b00) || (req_addr_i < MEM_BASE) || (offset >= MEM_SPAN);
    acc_ent.inst = '0;
    if (!acc_ent.err) acc_ent.inst = mem_q[offset[MEM_AW+1:2]];
  end

  always_ff @(posedge clk) begin
    if (init_wr_en_i) mem_q[init_wr_addr_i] <= init_wr_data_i;
  end

  if (LATENCY == 1) begin : g_direct
    assign push_vld = accept;
    assign push_ent = acc_ent;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    resp_t              ent_q [LATENCY-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= '0;
      end else if (flush_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= accept;
        for (int i = 1; i < LATENCY - 1; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      ent_q[0] <= acc_ent;
      for (int i = 1; i < LATENCY - 1; i++) ent_q[i] <= ent_q[i-1];
    end

    assign push_vld = vld_q[LATENCY-2];
    assign push_ent = ent_q[LATENCY-2];
  end

  always_comb begin
    fcnt_d = fcnt_q;
    if (push_vld && !pop)      fcnt_d = fcnt_q + CW'(1);
    else if (!push_vld && pop) fcnt_d = fcnt_q - CW'(1);
    occ_d = occ_q;
    if (accept && !pop)        occ_d = occ_q + CW'(1);
    else if (!accept && pop)   occ_d = occ_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      occ_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      occ_q    <= '0;
    end else begin
      if (push_vld) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)      rd_ptr_q <= next_ptr(rd_ptr_q);
      fcnt_q <= fcnt_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !flush_i) fifo_q[wr_ptr_q] <= push_ent;
  end

  assign head        = fifo_q[rd_ptr_q];
  assign resp_pc_o   = resp_valid_o ? head.pc   : '0;
  assign resp_inst_o = resp_valid_o ? head.inst : '0;
  assign resp_err_o  = resp_valid_o ? head.err  : 1'b0;

endmodule
